// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max pooling over a raster-order pixel stream.
// All channels are pooled in parallel; no backpressure is possible.
module maxpool2x2_stream #(
    parameter int N          = 16,
    parameter int CHANNEL    = 3,
    parameter int INPUT_SIZE = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 input_vld,
    input  logic [CHANNEL*N-1:0] input_din,
    output logic [CHANNEL*N-1:0] pool_dout,
    output logic                 pool_dout_vld,
    output logic                 pool_dout_end
);

    localparam int HALF = INPUT_SIZE / 2;
    localparam int CW   = $clog2(INPUT_SIZE + 1);
    localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0]        col;
    logic [CW-1:0]        row;
    logic [CHANNEL*N-1:0] hreg;
    logic [CHANNEL*N-1:0] hmax;
    logic [CHANNEL*N-1:0] pmax;
    logic [CHANNEL*N-1:0] lb_rd;
    logic [CHANNEL*N-1:0] linebuf [HALF];
    logic [AW-1:0]        lb_idx;
    logic                 col_last;
    logic                 row_last;

    assign col_last = (col == CW'(INPUT_SIZE - 1));
    assign row_last = (row == CW'(INPUT_SIZE - 1));
    assign lb_idx   = AW'(col >> 1);
    assign lb_rd    = linebuf[lb_idx];

    // Horizontal pair max, then vertical max against the stored upper row
    always_comb begin
        hmax = hreg;
        pmax = lb_rd;
        for (int c = 0; c < CHANNEL; c++) begin
            if ($signed(input_din[c*N +: N]) > $signed(hreg[c*N +: N]))
                hmax[c*N +: N] = input_din[c*N +: N];
        end
        for (int c = 0; c < CHANNEL; c++) begin
            if ($signed(hmax[c*N +: N]) > $signed(lb_rd[c*N +: N]))
                pmax[c*N +: N] = hmax[c*N +: N];
        end
    end

    // Line buffer: even rows park their horizontal maxima, never cleared
    always_ff @(posedge clk) begin
        if (!rst && input_vld && col[0] && !row[0])
            linebuf[lb_idx] <= hmax;
    end

    // Position tracking, horizontal register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            col           <= '0;
            row           <= '0;
            hreg          <= '0;
            pool_dout     <= '0;
            pool_dout_vld <= 1'b0;
            pool_dout_end <= 1'b0;
        end else begin
            pool_dout_vld <= 1'b0;
            pool_dout_end <= 1'b0;
            if (input_vld) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (!col[0]) begin
                    hreg <= input_din;
                end else if (row[0]) begin
                    pool_dout     <= pmax;
                    pool_dout_vld <= 1'b1;
                    pool_dout_end <= row_last && col_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: three instances of different
// geometry driven from one directed sequence, checked against a window model.
module tb_maxpool2x2_stream;

    typedef struct {
        int          which;
        int          cyc;
        logic [47:0] d;
        logic        e;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld4 = 1'b0, vld2 = 1'b0, vld6 = 1'b0;
    logic [15:0] din4 = '0;
    logic [31:0] din2 = '0;
    logic [47:0] din6 = '0;
    logic [15:0] dout4;
    logic [31:0] dout2;
    logic [47:0] dout6;
    logic        v4, v2, v6, e4, e2, e6;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [47:0] frame_q [$];
    int          beat_q [$];
    ev_t         mon_q [$];
    ev_t         exp_q [$];
    logic [47:0] last_d;

    maxpool2x2_stream #(.N(16), .CHANNEL(1), .INPUT_SIZE(4)) u4 (
        .clk(clk), .rst(rst), .input_vld(vld4), .input_din(din4),
        .pool_dout(dout4), .pool_dout_vld(v4), .pool_dout_end(e4));

    maxpool2x2_stream #(.N(16), .CHANNEL(2), .INPUT_SIZE(2)) u2 (
        .clk(clk), .rst(rst), .input_vld(vld2), .input_din(din2),
        .pool_dout(dout2), .pool_dout_vld(v2), .pool_dout_end(e2));

    maxpool2x2_stream #(.N(16), .CHANNEL(3), .INPUT_SIZE(6)) u6 (
        .clk(clk), .rst(rst), .input_vld(vld6), .input_din(din6),
        .pool_dout(dout6), .pool_dout_vld(v6), .pool_dout_end(e6));

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (v4 || e4) mon_q.push_back('{0, cyc, {32'b0, dout4}, e4});
        if (v2 || e2) mon_q.push_back('{1, cyc, {16'b0, dout2}, e2});
        if (v6 || e6) mon_q.push_back('{2, cyc, dout6, e6});
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic all_idle();
        vld4 = 1'b0;
        vld2 = 1'b0;
        vld6 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            all_idle();
        end
    endtask

    task automatic beat(input int which, input logic [47:0] d);
        @(posedge clk);
        #1;
        all_idle();
        case (which)
            0: begin vld4 = 1'b1; din4 = d[15:0]; end
            1: begin vld2 = 1'b1; din2 = d[31:0]; end
            default: begin vld6 = 1'b1; din6 = d; end
        endcase
        frame_q.push_back(d);
        beat_q.push_back(cyc);
    endtask

    function automatic logic [47:0] rnd48();
        return {$urandom(), $urandom()};
    endfunction

    // Max of the four pixels of window (i,j), per signed 16-bit channel
    function automatic logic [47:0] win_max(input int s, input int c_n,
                                            input int i, input int j);
        logic [47:0] r;
        logic [15:0] best, p;
        r = '0;
        for (int c = 0; c < c_n; c++) begin
            best = frame_q[(2*i)*s + 2*j][c*16 +: 16];
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++) begin
                    p = frame_q[(2*i+dr)*s + 2*j+dc][c*16 +: 16];
                    if ($signed(p) > $signed(best)) best = p;
                end
            r[c*16 +: 16] = best;
        end
        return r;
    endfunction

    // Windows fully covered by the beats fed so far, in output order
    task automatic add_expected(input int which, input int s, input int c_n);
        int t;
        for (int i = 0; i < s/2; i++)
            for (int j = 0; j < s/2; j++) begin
                t = (2*i+1)*s + 2*j + 1;
                if (t < frame_q.size())
                    exp_q.push_back('{which, beat_q[t] + 1, win_max(s, c_n, i, j),
                                      (i == s/2-1) && (j == s/2-1)});
            end
        frame_q.delete();
        beat_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        int n;
        chk({tag, "_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
        n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            chk({tag, "_dut"},  64'(mon_q[k].which), 64'(exp_q[k].which));
            chk({tag, "_data"}, 64'(mon_q[k].d),     64'(exp_q[k].d));
            chk({tag, "_end"},  64'(mon_q[k].e),     64'(exp_q[k].e));
            chk({tag, "_cyc"},  64'(mon_q[k].cyc),   64'(exp_q[k].cyc));
        end
        if (exp_q.size() > 0) last_d = exp_q[exp_q.size()-1].d;
        mon_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [47:0] negate(input logic [47:0] d);
        logic [47:0] r;
        for (int c = 0; c < 3; c++) r[c*16 +: 16] = -d[c*16 +: 16];
        return r;
    endfunction

    initial begin
        logic [47:0] fa [36];

        // Reset held with valid random beats: outputs stay zero
        vld4 = 1'b1; vld2 = 1'b1; vld6 = 1'b1;
        din4 = 16'($urandom()); din2 = $urandom(); din6 = rnd48();
        repeat (3) begin
            @(negedge clk);
            chk("rst_dout4", 64'(dout4), 64'd0);
            chk("rst_vld4",  64'(v4),    64'd0);
            chk("rst_end4",  64'(e4),    64'd0);
            chk("rst_dout6", 64'(dout6), 64'd0);
            chk("rst_vld6",  64'(v6 | e6 | v2 | e2), 64'd0);
            @(posedge clk);
            #1;
            din4 = 16'($urandom()); din2 = $urandom(); din6 = rnd48();
        end
        rst = 1'b0;
        all_idle();

        // Basic ramp frame
        for (int k = 0; k < 16; k++) beat(0, 48'(k));
        add_expected(0, 4, 1);
        idle(4);
        check_outputs("basic");
        @(negedge clk);
        chk("hold", 64'(dout4), 64'(last_d));
        chk("hold_const", 64'(dout4), 64'd15);

        // Gapped random frame
        for (int k = 0; k < 16; k++) begin
            idle($urandom_range(0, 3));
            beat(0, 48'($urandom_range(0, 65535)));
        end
        add_expected(0, 4, 1);
        idle(4);
        check_outputs("gap");

        // Signed compare, 2x2 two-channel
        beat(1, {16'b0, 16'h8000, 16'hFFFD});
        beat(1, {16'b0, 16'h7FFF, 16'hFFF9});
        beat(1, {16'b0, 16'h0000, 16'hFFFF});
        beat(1, {16'b0, 16'hFFFF, 16'hFFEC});
        add_expected(1, 2, 2);
        idle(1);
        @(negedge clk);
        chk("sign_dout", 64'(dout2), 64'h7FFF_FFFF);
        chk("sign_vld",  64'(v2),    64'd1);
        chk("sign_end",  64'(e2),    64'd1);
        idle(3);
        check_outputs("sign");

        // Random 2x2 frames back to back
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) beat(1, {16'b0, $urandom()});
            add_expected(1, 2, 2);
        end
        idle(3);
        check_outputs("rnd2");

        // Two 6x6 frames, second negated, no gap
        for (int k = 0; k < 36; k++) begin
            fa[k] = rnd48();
            beat(2, fa[k]);
        end
        add_expected(2, 6, 3);
        for (int k = 0; k < 36; k++) beat(2, negate(fa[k]));
        add_expected(2, 6, 3);
        idle(4);
        check_outputs("b2b");

        // Reset after 10 beats, then a constant frame
        for (int k = 0; k < 10; k++) beat(0, 48'($urandom_range(0, 65535)));
        add_expected(0, 4, 1);
        @(posedge clk);
        #1;
        all_idle();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_vld", 64'(v4), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_vld", 64'(v4), 64'd0);
        for (int k = 0; k < 16; k++) beat(0, 48'h0042);
        add_expected(0, 4, 1);
        idle(4);
        check_outputs("midrst");

        // Reset coincident with the beat that would emit a window
        for (int k = 0; k < 5; k++) beat(0, 48'($urandom_range(0, 255)));
        @(posedge clk);
        #1;
        rst = 1'b1;
        vld4 = 1'b1;
        din4 = 16'h7FFF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        all_idle();
        @(negedge clk);
        chk("drop_vld", 64'(v4), 64'd0);
        chk("drop_dout", 64'(dout4), 64'd0);
        frame_q.delete();
        beat_q.delete();
        for (int k = 0; k < 16; k++) beat(0, 48'($urandom_range(0, 65535)));
        add_expected(0, 4, 1);
        idle(4);
        check_outputs("drop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage. Sits directly downstream of the depthwise-separable conv stage and consumes its conv_dout / conv_dout_vld stream.
- Input is one pixel per valid beat, all channels in parallel, in raster order (row-major, column fastest).
- Outputs one pooled pixel per 2x2 window, all channels in parallel, with a valid pulse and an end-of-frame flag.
- No backpressure: the producer cannot be stalled.

Parameters:
- N, 16: bit width of one signed fixed-point channel value.
- CHANNEL, 3: number of channels carried in parallel.
- INPUT_SIZE, 6: input frame width and height. Must be even and >= 2. Output frame is INPUT_SIZE/2 x INPUT_SIZE/2.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- input_vld  input  1  input_din holds a valid pixel this cycle.
- input_din  input  CHANNEL*N  pixel; channel c occupies bits [c*N +: N], two's complement.
- pool_dout  output  CHANNEL*N  pooled pixel, same channel packing as input_din.
- pool_dout_vld  output  1  one-cycle pulse per pooled pixel.
- pool_dout_end  output  1  one-cycle pulse coincident with pool_dout_vld on the last pooled pixel of a frame.

Behaviour:
- Reset is synchronous and active-high; the single clock is clk.
- On rst: col=0, row=0, hreg=0, pool_dout=0, pool_dout_vld=0, pool_dout_end=0. The line buffer is not cleared; it is always written before it is read.
- col counts 0..INPUT_SIZE-1 and advances only on input_vld. It wraps to 0 at INPUT_SIZE-1 and increments row at the same time.
- row counts 0..INPUT_SIZE-1 and wraps to 0 after the last pixel, so the block is ready for the next frame with no idle cycle.
- Gaps (input_vld=0) may occur at any point. When input_vld=0, all state holds.
- All comparisons are signed, per channel, and independent. max(a,b) returns a when a>=b; on a tie the value is identical either way.
- Beat with col even: hreg <= input_din (all channels).
- Beat with col odd: hmax = max(hreg, input_din) per channel.
  - row even: linebuf[col>>1] <= hmax.
  - row odd: pool_dout <= max(linebuf[col>>1], hmax); pool_dout_vld <= 1.
- Line buffer: INPUT_SIZE/2 entries of CHANNEL*N bits; register array or distributed RAM with a combinational read.
- Latency: pool_dout_vld rises exactly 1 clk after the input beat at (row odd, col odd).
- Output cadence: back-to-back input yields a pooled output every 2nd beat of odd rows and none during even rows.
- pool_dout_end = 1 with the output produced by the beat at row=col=INPUT_SIZE-1; otherwise 0.
- pool_dout holds its last value when pool_dout_vld=0.
- Per-frame totals: (INPUT_SIZE/2)^2 vld pulses and exactly one end pulse.
- Extra beats after a frame are the first pixel(s) of the next frame; there is no frame-start signal.
- rst asserted mid-frame:
  - Partial window and line-buffer contents are discarded.
  - A vld/end pulse due in the same cycle is suppressed.
  - The first input_vld after rst deasserts is pixel (0,0).
- rst and input_vld both high in one cycle: rst wins and the beat is dropped.
- Mapping from the upstream conv: input_vld=conv_dout_vld, input_din=conv_dout, INPUT_SIZE=conv OUTPUT_SIZE, CHANNEL=conv OUTPUT_CHANNEL. conv_dout_end is not needed; position is tracked internally.

Test Plan:
- Basic frame (INPUT_SIZE=4, CHANNEL=1, N=16). Input 4x4 ramp 0..15 back-to-back -> outputs 5, 7, 13, 15, each 1 clk after input beats 5, 7, 13, 15 (0-based). end pulses only with 15; exactly 4 vld pulses.
- Signed compare (INPUT_SIZE=2, CHANNEL=2).
  - Channel 0 pixels: -3, -7, -1, -20. Channel 1 pixels: 0x8000, 0x7FFF, 0, -1.
  - Required: single output, ch0=-1 (0xFFFF), ch1=0x7FFF, with vld=end=1.
- Gapped input: frame from the basic-frame case with input_vld low for 0..3 random cycles between beats -> identical output values and order; each vld exactly 1 clk after its triggering beat.
- Back-to-back frames (INPUT_SIZE=6). Two 36-beat frames with no gap, the second frame = first frame negated -> 9 correct maxima per frame against a software model; end pulses on output #9 and #18 only.
- Reset mid-frame (INPUT_SIZE=4).
  - Feed 10 beats of frame A, pulse rst one cycle, then a full frame B of all 0x0042.
  - Required: no outputs during or right after rst; 4 outputs of 0x0042; end on the 4th.
- Reset values: hold rst for 3 cycles with input_vld=1 and random data -> pool_dout=0, pool_dout_vld=0, pool_dout_end=0 throughout, and no pulse after rst is released until a full window arrives.
